// File: rtl/bbox_stream_engine.sv
// Streaming bounding-box finder over a raster-order pixel byte stream.
// Optional: define BBOX_COUNT_EN to add the fg_count port and counter.
module bbox_stream_engine #(
  parameter  int WIDTH    = 100,
  parameter  int HEIGHT   = 100,
  parameter  int CHANNELS = 3,
  parameter  int THRESH   = 128,
  localparam int MAXD     = (WIDTH > HEIGHT) ? WIDTH : HEIGHT,
  localparam int COORD_W  = (MAXD > 1) ? $clog2(MAXD) : 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               wr_en,
  input  logic [7:0]         data_in,
  output logic               busy,
  output logic               done,
  output logic               box_valid,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_max
`ifdef BBOX_COUNT_EN
  , output logic [$clog2(WIDTH*HEIGHT+1)-1:0] fg_count
`endif
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
  localparam logic [8:0]         TH      = 9'(THRESH);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             r_state;
  logic               r_busy, r_done, r_valid;
  logic [CH_W-1:0]    r_ch;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_fg, r_seen;
  logic [COORD_W-1:0] r_xmin, r_ymin, r_xmax, r_ymax;
  logic [COORD_W-1:0] r_oxmin, r_oymin, r_oxmax, r_oymax;

  logic               w_acc, w_lt, w_fg, w_pix_end, w_hit, w_last, w_seen;
  logic [COORD_W-1:0] w_xmin, w_ymin, w_xmax, w_ymax;

  // start always wins over a coincident byte
  assign w_acc     = (r_state == ACCUM) && wr_en && !start;
  assign w_lt      = {1'b0, data_in} < TH;
  assign w_fg      = ((r_ch == '0) || r_fg) && w_lt;
  assign w_pix_end = w_acc && (r_ch == CH_LAST);
  assign w_hit     = w_pix_end && w_fg;
  assign w_last    = w_pix_end && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_seen    = r_seen || w_hit;

  assign w_xmin = (w_hit && (r_x < r_xmin)) ? r_x : r_xmin;
  assign w_ymin = (w_hit && (r_y < r_ymin)) ? r_y : r_ymin;
  assign w_xmax = (w_hit && (r_x > r_xmax)) ? r_x : r_xmax;
  assign w_ymax = (w_hit && (r_y > r_ymax)) ? r_y : r_ymax;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fg    <= 1'b0;
      r_seen  <= 1'b0;
      r_xmin  <= '1;
      r_ymin  <= '1;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_oxmin <= '0;
      r_oymin <= '0;
      r_oxmax <= '0;
      r_oymax <= '0;
    end else if (start) begin
      r_state <= ACCUM;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fg    <= 1'b0;
      r_seen  <= 1'b0;
      r_xmin  <= '1;
      r_ymin  <= '1;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_oxmin <= '0;
      r_oymin <= '0;
      r_oxmax <= '0;
      r_oymax <= '0;
    end else if (w_acc) begin
      r_ch   <= w_pix_end ? '0 : r_ch + CH_W'(1);
      r_fg   <= w_fg;
      r_seen <= w_seen;
      r_xmin <= w_xmin;
      r_ymin <= w_ymin;
      r_xmax <= w_xmax;
      r_ymax <= w_ymax;
      if (w_pix_end) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
        end else begin
          r_x <= r_x + COORD_W'(1);
        end
      end
      // empty frame reports an all-zero box
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_valid <= w_seen;
        r_oxmin <= w_seen ? w_xmin : '0;
        r_oymin <= w_seen ? w_ymin : '0;
        r_oxmax <= w_seen ? w_xmax : '0;
        r_oymax <= w_seen ? w_ymax : '0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign box_valid = r_valid;
  assign x_min     = r_oxmin;
  assign y_min     = r_oymin;
  assign x_max     = r_oxmax;
  assign y_max     = r_oymax;

`ifdef BBOX_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH*HEIGHT+1);
  logic [CNT_W-1:0] r_cnt, r_ocnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_ocnt <= '0;
    end else if (start) begin
      r_cnt  <= '0;
      r_ocnt <= '0;
    end else begin
      if (w_hit)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_last)
        r_ocnt <= r_cnt + CNT_W'(w_hit);
    end
  end

  assign fg_count = r_ocnt;
`endif

endmodule
